// File: rtl/int_pkg.sv
// Shared types, bit positions and helpers for the 8051-style interrupt controller.
package int_pkg;

    localparam int NUM_SRC = 5;

    typedef logic [2:0] src_idx_t;

    // Source indices in natural priority order; they also equal the IE/IP/TCON-flag bit positions.
    localparam src_idx_t SRC_IE0 = 3'd0;
    localparam src_idx_t SRC_TF0 = 3'd1;
    localparam src_idx_t SRC_IE1 = 3'd2;
    localparam src_idx_t SRC_TF1 = 3'd3;
    localparam src_idx_t SRC_SER = 3'd4;

    localparam int IE_EX0 = 0;
    localparam int IE_ET0 = 1;
    localparam int IE_EX1 = 2;
    localparam int IE_ET1 = 3;
    localparam int IE_ES  = 4;
    localparam int IE_EA  = 7;

    localparam int IP_PX0 = 0;
    localparam int IP_PT0 = 1;
    localparam int IP_PX1 = 2;
    localparam int IP_PT1 = 3;
    localparam int IP_PS  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } int_state_e;

    function automatic src_idx_t lowest_set(input logic [NUM_SRC-1:0] v);
        src_idx_t idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = src_idx_t'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input src_idx_t    src);
        return base + stride * {13'd0, src};
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-facing vectored request/acknowledge handshake of the interrupt controller.
interface int_ctrl_if;
    logic        int_req;
    logic [15:0] int_vec;
    logic [1:0]  in_service;
    logic        int_ack;
    logic        reti;

    modport master (output int_req, int_vec, in_service, input int_ack, reti);
    modport slave  (input int_req, int_vec, in_service, output int_ack, reti);
endinterface

// File: rtl/int_sync_edge.sv
// Synchroniser for an asynchronous active-low pin plus a falling-edge detector.
module int_sync_edge #(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n,
    output logic active,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_n};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: synchronous reset to the idle pin level (1) so no false edge appears on release;
    // sequential state uses <= only so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign active = ~sync_q[SYNC_STAGES-1];
    assign fall   = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// Two-level priority interrupt controller: flag capture, arbitration under IE/IP,
// vectored request/acknowledge to the CPU and in-service nesting until RETI.
module int_ctrl
    import int_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0003,
    parameter int          VEC_STRIDE  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t0_ovf,
    input  logic             t1_ovf,
    input  logic             ext_int0_n,
    input  logic             ext_int1_n,
    input  logic             it0,
    input  logic             it1,
    input  logic             ri,
    input  logic             ti,
    input  logic [7:0]       ie,
    input  logic [7:0]       ip,
    input  logic             tcon_we,
    input  logic [3:0]       tcon_wdata,
    output logic [3:0]       tcon_flags,
    int_ctrl_if.master       cpu
);

    logic ie0_act, ie0_fall, ie1_act, ie1_fall;

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_int0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_n  (ext_int0_n),
        .active (ie0_act),
        .fall   (ie0_fall)
    );

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_int1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_n  (ext_int1_n),
        .active (ie1_act),
        .fall   (ie1_fall)
    );

    logic [1:0]  ovf_prev_q, ovf_prev_d;
    logic [3:0]  flag_q, flag_d;        // {TF1,IE1,TF0,IE0}, bit n is source n
    int_state_e  state_q, state_d;
    logic        int_req_q, int_req_d;
    logic [15:0] int_vec_q, int_vec_d;
    src_idx_t    req_src_q, req_src_d;
    logic        req_lvl_q, req_lvl_d;
    logic [1:0]  svc_q, svc_d;          // {high_active, low_active}

    logic [NUM_SRC-1:0] src_flag, pend, pend_hi, pend_lo;
    src_idx_t           win_src;
    logic               win_lvl, win_ok;
    logic               ack_take;
    logic [3:0]         hw_set, ack_clr, level_mask, level_val;

    // Bits 6:5 of IE and 7:5 of IP are reserved in the SFR map.
    logic unused_sfr_bits;
    assign unused_sfr_bits = ^{ie[6:5], ip[7:5]};

    always_comb begin
        src_flag = {ri | ti, flag_q};
        pend     = src_flag & ie[NUM_SRC-1:0] & {NUM_SRC{ie[IE_EA]}};
        pend_hi  = pend & ip[NUM_SRC-1:0];
        pend_lo  = pend & ~ip[NUM_SRC-1:0];
        win_lvl  = |pend_hi;
        win_src  = lowest_set(win_lvl ? pend_hi : pend_lo);
        // A blocked high winner implies in_service[1]=1, which also blocks every low source.
        win_ok   = (|pend) & (win_lvl ? ~svc_q[1] : (svc_q == 2'b00));
        ack_take = (state_q == REQ) & cpu.int_ack;
    end

    always_comb begin
        ovf_prev_d = {t1_ovf, t0_ovf};
        hw_set     = {t1_ovf & ~ovf_prev_q[1], ie1_fall, t0_ovf & ~ovf_prev_q[0], ie0_fall};
        ack_clr    = ack_take ? (4'b0001 << req_src_q) : 4'b0000;
        level_mask = {1'b0, ~it1, 1'b0, ~it0};
        level_val  = {1'b0, ie1_act, 1'b0, ie0_act};

        // Software write is weakest, then the ack clear, then a hardware set.
        flag_d = tcon_we ? tcon_wdata : flag_q;
        flag_d = flag_d & ~ack_clr;
        flag_d = flag_d | hw_set;
        flag_d = (flag_d & ~level_mask) | (level_val & level_mask);
    end

    always_comb begin
        svc_d = svc_q;
        if (cpu.reti) begin
            if (svc_q[1]) svc_d[1] = 1'b0;
            else          svc_d[0] = 1'b0;
        end
        if (ack_take) svc_d[req_lvl_q] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        int_vec_d = int_vec_q;
        req_src_d = req_src_q;
        req_lvl_d = req_lvl_q;
        case (state_q)
            IDLE: begin
                if (win_ok) begin
                    state_d   = REQ;
                    int_req_d = 1'b1;
                    int_vec_d = vec_addr(VEC_BASE, 16'(VEC_STRIDE), win_src);
                    req_src_d = win_src;
                    req_lvl_d = win_lvl;
                end
            end
            REQ: begin
                // The ack always takes the source behind the vector the CPU already saw.
                if (ack_take) begin
                    state_d   = IDLE;
                    int_req_d = 1'b0;
                end else if (win_ok) begin
                    int_vec_d = vec_addr(VEC_BASE, 16'(VEC_STRIDE), win_src);
                    req_src_d = win_src;
                    req_lvl_d = win_lvl;
                end else begin
                    state_d   = IDLE;
                    int_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_prev_q <= 2'b00;
            flag_q     <= 4'b0000;
            state_q    <= IDLE;
            int_req_q  <= 1'b0;
            int_vec_q  <= 16'h0000;
            req_src_q  <= SRC_IE0;
            req_lvl_q  <= 1'b0;
            svc_q      <= 2'b00;
        end else begin
            ovf_prev_q <= ovf_prev_d;
            flag_q     <= flag_d;
            state_q    <= state_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            req_src_q  <= req_src_d;
            req_lvl_q  <= req_lvl_d;
            svc_q      <= svc_d;
        end
    end

    assign tcon_flags     = flag_q;
    assign cpu.int_req    = int_req_q;
    assign cpu.int_vec    = int_vec_q;
    assign cpu.in_service = svc_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: cycle-level reference model with an every-cycle compare,
// plus hand-computed literal checks for each scenario.
`timescale 1ns/1ps
module tb_int_ctrl;

    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] VEC_BASE    = 16'h0003;
    localparam int          VEC_STRIDE  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       t0_ovf, t1_ovf, ext_int0_n, ext_int1_n, it0, it1, ri, ti, tcon_we;
    logic [7:0] ie, ip;
    logic [3:0] tcon_wdata;
    logic [3:0] tcon_flags;

    int_ctrl_if cpu_if ();

    int_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .VEC_BASE    (VEC_BASE),
        .VEC_STRIDE  (VEC_STRIDE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .t0_ovf     (t0_ovf),
        .t1_ovf     (t1_ovf),
        .ext_int0_n (ext_int0_n),
        .ext_int1_n (ext_int1_n),
        .it0        (it0),
        .it1        (it1),
        .ri         (ri),
        .ti         (ti),
        .ie         (ie),
        .ip         (ip),
        .tcon_we    (tcon_we),
        .tcon_wdata (tcon_wdata),
        .tcon_flags (tcon_flags),
        .cpu        (cpu_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: flags per source, pin sample history, and the
    // request/in-service bookkeeping, evaluated once per rising edge.
    // ------------------------------------------------------------------
    bit          m_flag [4];
    bit          m_prev [2];
    bit          m_hist [2][SYNC_STAGES+1];  // m_hist[p][k] = pin sampled k+1 edges ago
    bit          m_req;
    int          m_src, m_lvl;
    logic [15:0] m_vec;
    bit          m_svc  [2];                 // index 1 = high level

    always @(posedge clk) begin : model
        int best, best_lvl, served;
        bit elig;
        bit src_on [5];
        bit hw_set [4];
        bit lvl_val [2];
        bit fell [2];
        bit pin_now [2];
        if (!rst_n) begin
            foreach (m_flag[s]) m_flag[s] = 1'b0;
            foreach (m_prev[s]) m_prev[s] = 1'b0;
            foreach (m_hist[p, k]) m_hist[p][k] = 1'b1;
            m_req = 1'b0; m_src = 0; m_lvl = 0; m_vec = '0;
            m_svc[0] = 1'b0; m_svc[1] = 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) src_on[s] = m_flag[s];
            src_on[4] = ri | ti;
            best = -1; best_lvl = 0;
            for (int lvl = 1; lvl >= 0; lvl--)
                for (int s = 0; s < 5; s++)
                    if (best < 0 && src_on[s] && ie[s] && ie[7] && (int'(ip[s]) == lvl)) begin
                        best = s; best_lvl = lvl;
                    end
            elig = (best >= 0) && (best_lvl == 1 ? !m_svc[1] : (!m_svc[1] && !m_svc[0]));
            served = (m_req && cpu_if.int_ack) ? m_src : -1;

            if (cpu_if.reti) begin
                if (m_svc[1]) m_svc[1] = 1'b0;
                else          m_svc[0] = 1'b0;
            end
            if (served >= 0) m_svc[m_lvl] = 1'b1;

            pin_now[0] = ext_int0_n; pin_now[1] = ext_int1_n;
            for (int p = 0; p < 2; p++) begin
                fell[p]    = m_hist[p][SYNC_STAGES] && !m_hist[p][SYNC_STAGES-1];
                lvl_val[p] = !m_hist[p][SYNC_STAGES-1];
            end
            hw_set[0] = fell[0];
            hw_set[1] = t0_ovf && !m_prev[0];
            hw_set[2] = fell[1];
            hw_set[3] = t1_ovf && !m_prev[1];
            for (int s = 0; s < 4; s++) begin
                if ((s == 0 && !it0) || (s == 2 && !it1)) begin
                    m_flag[s] = lvl_val[s/2];
                end else begin
                    if (tcon_we)     m_flag[s] = tcon_wdata[s];
                    if (served == s) m_flag[s] = 1'b0;
                    if (hw_set[s])   m_flag[s] = 1'b1;
                end
            end
            m_prev[0] = t0_ovf; m_prev[1] = t1_ovf;
            for (int p = 0; p < 2; p++) begin
                for (int k = SYNC_STAGES; k > 0; k--) m_hist[p][k] = m_hist[p][k-1];
                m_hist[p][0] = pin_now[p];
            end

            if (served >= 0) m_req = 1'b0;
            else if (elig) begin
                m_req = 1'b1;
                m_src = best;
                m_lvl = best_lvl;
                m_vec = 16'(VEC_BASE + best * VEC_STRIDE);
            end else m_req = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_int_req", {15'd0, cpu_if.int_req}, {15'd0, m_req});
            if (m_req) check("mdl_int_vec", cpu_if.int_vec, m_vec);
            check("mdl_tcon_flags", {12'd0, tcon_flags},
                  {12'd0, m_flag[3], m_flag[2], m_flag[1], m_flag[0]});
            check("mdl_in_service", {14'd0, cpu_if.in_service}, {14'd0, m_svc[1], m_svc[0]});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after a rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        cpu_if.int_ack = 1'b1;
        step();
        cpu_if.int_ack = 1'b0;
    endtask

    task automatic reti_pulse();
        cpu_if.reti = 1'b1;
        step();
        cpu_if.reti = 1'b0;
    endtask

    task automatic wait_req(input int budget, input string name);
        int k;
        k = 0;
        while (cpu_if.int_req !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        check(name, {15'd0, cpu_if.int_req}, 16'd1);
    endtask

    task automatic expect_req(input string name, input logic [15:0] vec);
        check({name, "_req"}, {15'd0, cpu_if.int_req}, 16'd1);
        check({name, "_vec"}, cpu_if.int_vec, vec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        t0_ovf = 0; t1_ovf = 0; ext_int0_n = 1; ext_int1_n = 1;
        it0 = 1; it1 = 1; ri = 0; ti = 0; ie = 8'h00; ip = 8'h00;
        tcon_we = 0; tcon_wdata = 4'h0;
        cpu_if.int_ack = 1'b0; cpu_if.reti = 1'b0;
        step(2);
        cmp_en = 1'b1;
        check("rst_flags", {12'd0, tcon_flags}, 16'd0);
        check("rst_req", {15'd0, cpu_if.int_req}, 16'd0);
        check("rst_vec", cpu_if.int_vec, 16'h0000);
        check("rst_svc", {14'd0, cpu_if.in_service}, 16'd0);
        rst_n = 1'b1;
        step();

        // Timer 0 overflow held high: one flag, one request, vector 0x000B.
        ie = 8'h82;
        t0_ovf = 1;
        step();
        check("t0_flag_set", {12'd0, tcon_flags}, 16'h0002);
        check("t0_req_not_yet", {15'd0, cpu_if.int_req}, 16'd0);
        step();
        expect_req("t0", 16'h000B);
        ack_pulse();
        check("t0_ack_flag", {12'd0, tcon_flags}, 16'h0000);
        check("t0_ack_req", {15'd0, cpu_if.int_req}, 16'd0);
        check("t0_ack_svc", {14'd0, cpu_if.in_service}, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t0_held_no_rereq", {15'd0, cpu_if.int_req}, 16'd0);
        end
        t0_ovf = 0;
        reti_pulse();
        check("t0_reti_svc", {14'd0, cpu_if.in_service}, 16'd0);

        // Priority: high-level TF1 beats IE0; IE0 waits for reti.
        ie = 8'h8F; ip = 8'h08;
        tcon_we = 1; tcon_wdata = 4'b1001;
        step();
        tcon_we = 0; tcon_wdata = 4'h0;
        check("pri_flags", {12'd0, tcon_flags}, 16'h0009);
        step();
        expect_req("pri_tf1", 16'h001B);
        ack_pulse();
        check("pri_svc_hi", {14'd0, cpu_if.in_service}, 16'h0002);
        check("pri_ie0_kept", {12'd0, tcon_flags}, 16'h0001);
        step(3);
        check("pri_ie0_held", {15'd0, cpu_if.int_req}, 16'd0);
        reti_pulse();
        check("pri_reti_svc", {14'd0, cpu_if.in_service}, 16'd0);
        step();
        expect_req("pri_ie0", 16'h0003);
        ack_pulse();
        check("pri_ie0_svc", {14'd0, cpu_if.in_service}, 16'h0001);
        reti_pulse();

        // Nesting: high-level IE1 edge interrupts a low-level TF0 service.
        ip = 8'h04;
        t0_ovf = 1;
        step();
        t0_ovf = 0;
        step();
        expect_req("nest_tf0", 16'h000B);
        ack_pulse();
        check("nest_svc_lo", {14'd0, cpu_if.in_service}, 16'h0001);
        ext_int1_n = 0;
        step(3);
        check("nest_ie1_flag", {12'd0, tcon_flags}, 16'h0004);
        check("nest_latency_early", {15'd0, cpu_if.int_req}, 16'd0);
        step();
        expect_req("nest_ie1", 16'h0013);
        ack_pulse();
        ext_int1_n = 1;
        check("nest_svc_both", {14'd0, cpu_if.in_service}, 16'h0003);
        check("nest_ie1_clr", {12'd0, tcon_flags}, 16'h0000);
        cpu_if.reti = 1'b1;
        step();
        check("nest_reti1", {14'd0, cpu_if.in_service}, 16'h0001);
        step();
        check("nest_reti2", {14'd0, cpu_if.in_service}, 16'h0000);
        cpu_if.reti = 1'b0;
        step(2);
        check("nest_idle", {15'd0, cpu_if.int_req}, 16'd0);

        // INT0 level mode: flag follows the pin and survives ack.
        it0 = 0; ie = 8'h81; ip = 8'h00;
        ext_int0_n = 0;
        step(3);
        check("lvl_flag", {12'd0, tcon_flags}, 16'h0001);
        step();
        expect_req("lvl", 16'h0003);
        ack_pulse();
        check("lvl_survives_ack", {12'd0, tcon_flags}, 16'h0001);
        check("lvl_svc", {14'd0, cpu_if.in_service}, 16'h0001);
        step(2);
        check("lvl_held", {15'd0, cpu_if.int_req}, 16'd0);
        reti_pulse();
        step();
        expect_req("lvl_rereq", 16'h0003);
        ack_pulse();
        ext_int0_n = 1;
        step(4);
        check("lvl_released", {12'd0, tcon_flags}, 16'h0000);
        reti_pulse();
        step(2);
        check("lvl_idle", {15'd0, cpu_if.int_req}, 16'd0);

        // INT0 edge mode: one pulse, one request, cleared on ack.
        it0 = 1;
        ext_int0_n = 0;
        step(2);
        ext_int0_n = 1;
        wait_req(6, "edge_req_timeout");
        check("edge_vec", cpu_if.int_vec, 16'h0003);
        ack_pulse();
        check("edge_ack_clr", {12'd0, tcon_flags}, 16'h0000);
        step(4);
        check("edge_single", {15'd0, cpu_if.int_req}, 16'd0);
        reti_pulse();

        // Withdrawal by software write, and hardware set winning over it.
        ie = 8'h88;
        t1_ovf = 1;
        step();
        t1_ovf = 0;
        step();
        expect_req("wd_tf1", 16'h001B);
        tcon_we = 1; tcon_wdata = 4'h0;
        step();
        tcon_we = 0;
        check("wd_flag_clr", {12'd0, tcon_flags}, 16'h0000);
        step();
        check("wd_req_drop", {15'd0, cpu_if.int_req}, 16'd0);
        t1_ovf = 1;
        step();
        t1_ovf = 0;
        step();
        expect_req("wd2_tf1", 16'h001B);
        t1_ovf = 1; tcon_we = 1; tcon_wdata = 4'h0;
        step();
        tcon_we = 0;
        check("wd2_hw_wins", {12'd0, tcon_flags}, 16'h0008);
        step();
        expect_req("wd2_kept", 16'h001B);
        ack_pulse();
        t1_ovf = 0;
        check("wd2_ack_clr", {12'd0, tcon_flags}, 16'h0000);
        reti_pulse();

        // Serial source: ri|ti level, never cleared by the block.
        ie = 8'h90;
        ri = 1;
        step();
        expect_req("ser", 16'h0023);
        ack_pulse();
        check("ser_svc", {14'd0, cpu_if.in_service}, 16'h0001);
        ri = 0; ti = 1;
        reti_pulse();
        step();
        expect_req("ser_ti", 16'h0023);
        ti = 0;
        step();
        check("ser_withdraw", {15'd0, cpu_if.int_req}, 16'd0);

        // Reset in the middle of a request, with a low-level service active.
        ie = 8'h8A; ip = 8'h02;
        t1_ovf = 1;
        step();
        t1_ovf = 0;
        step();
        expect_req("rst_pre_tf1", 16'h001B);
        ack_pulse();
        check("rst_pre_svc", {14'd0, cpu_if.in_service}, 16'h0001);
        t0_ovf = 1;
        step(2);
        expect_req("rst_pre_tf0", 16'h000B);
        rst_n = 0;
        step();
        check("rst_mid_flags", {12'd0, tcon_flags}, 16'h0000);
        check("rst_mid_req", {15'd0, cpu_if.int_req}, 16'd0);
        check("rst_mid_vec", cpu_if.int_vec, 16'h0000);
        check("rst_mid_svc", {14'd0, cpu_if.in_service}, 16'h0000);
        rst_n = 1;
        step();
        check("rst_tf0_reset", {12'd0, tcon_flags}, 16'h0002);
        step();
        expect_req("rst_post_tf0", 16'h000B);
        ack_pulse();
        check("rst_post_svc", {14'd0, cpu_if.in_service}, 16'h0002);
        step(3);
        check("rst_post_once", {15'd0, cpu_if.int_req}, 16'd0);
        t0_ovf = 0;
        reti_pulse();
        check("rst_post_reti", {14'd0, cpu_if.in_service}, 16'h0000);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- 8051-style two-level priority interrupt controller, directly downstream of the timer pair.
- Edge-detects timer overflow outputs (t_o of timer 0 and timer 1) into TF0/TF1, and samples INT0/INT1 pins into IE0/IE1. It also takes the serial RI/TI flags.
- Arbitrates the pending sources under IE/IP and drives a vectored request/acknowledge handshake to the CPU core.
- Tracks in-service nesting until RETI.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on the ext_int*_n pins (minimum 2).
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, address spacing between consecutive source vectors.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- t0_ovf  in  1  timer 0 overflow level (timer t_o)
- t1_ovf  in  1  timer 1 overflow level
- ext_int0_n  in  1  INT0 pin, asynchronous, active-low
- ext_int1_n  in  1  INT1 pin, asynchronous, active-low
- it0  in  1  TCON.IT0: 1 = falling-edge mode, 0 = low-level mode
- it1  in  1  TCON.IT1
- ri  in  1  serial receive flag, level
- ti  in  1  serial transmit flag, level
- ie  in  8  IE SFR {EA,-,-,ES,ET1,EX1,ET0,EX0}
- ip  in  8  IP SFR {-,-,-,PS,PT1,PX1,PT0,PX0}
- tcon_we  in  1  software write strobe for the flags
- tcon_wdata  in  4  {TF1,IE1,TF0,IE0} write data
- int_ack  in  1  1-cycle CPU pulse: vector accepted
- reti  in  1  1-cycle CPU pulse: RETI executed
- tcon_flags  out  4  {TF1,IE1,TF0,IE0} for SFR readback
- int_req  out  1  interrupt request to the CPU
- int_vec  out  16  vector address, valid while int_req=1
- in_service  out  2  {high_active, low_active}

Behaviour:
- Reset: tcon_flags=0, int_req=0, int_vec=0, in_service=0, FSM=IDLE. All edge-detect and synchroniser registers clear to the inactive level (ovf=0, pin=1).
- TF0/TF1:
  - Set on the rising edge of t*_ovf: current=1 and previous=0. A held-high ovf sets the flag once.
  - Cleared by hardware in the cycle int_ack accepts that source, or by a software write.
- IE0/IE1, edge mode:
  - Set on a synchronised 1->0 transition.
  - Cleared by hardware on ack of that source, or by a software write.
- IE0/IE1, level mode:
  - Flag equals the inverted synchronised pin every cycle.
  - Not cleared by ack; a software write has no lasting effect.
- Serial source: request = ri|ti. The block never clears ri or ti.
- Flag precedence within a cycle: hardware set > hardware ack-clear > software write.
- Sources in natural order 0..4 are IE0, TF0, IE1, TF1, SER. Source n is pending when its flag is 1, its enable bit is 1, and EA=1.
- Arbitration, combinational on the registered flags:
  - Any pending high-level (IP bit=1) source beats any low-level source.
  - Within a level, the lowest index wins.
- Eligibility:
  - High-level winner: allowed when in_service[1]=0.
  - Low-level winner: allowed when in_service==2'b00.
- FSM IDLE:
  - Eligible winner exists -> REQ.
  - int_req=1 and int_vec = VEC_BASE + n*VEC_STRIDE are registered one cycle after the flag is set.
- FSM REQ:
  - Re-arbitrates every cycle; int_vec tracks the current winner and int_req stays 1.
  - No eligible winner left (flag cleared, enable dropped, EA=0) -> int_req=0, back to IDLE.
  - int_ack=1 -> latch the current winner, set in_service[its level], apply the hardware clear, int_req=0 next cycle, FSM -> IDLE.
  - An ack in the same cycle a higher source becomes pending still takes the registered int_vec.
- int_ack while int_req=0 is ignored.
- reti clears in_service[1] if set, otherwise in_service[0]. reti with in_service==0 is ignored.
- reti and int_ack in the same cycle: the reti clear is applied first, then the ack set.
- A request is re-raised no earlier than 1 cycle after ack or reti.
- Latency:
  - Pin edge to int_req: SYNC_STAGES+2 cycles.
  - Overflow edge to int_req: 2 cycles.

Decomposition:
- Package int_pkg holds:
  - source index constants SRC_IE0..SRC_SER;
  - the FSM state enum {IDLE, REQ};
  - IE/IP bit-position constants;
  - a vector function for VEC_BASE/VEC_STRIDE.
- One sub-module, int_sync_edge: parameterised SYNC_STAGES synchroniser plus falling-edge detector. Instantiated for INT0 and INT1.
- Timer overflow edges are detected inline with a single previous-value flop, since the timer inputs are already synchronous.

Test Plan:
- Timer overflow: IE=8'h82, t0_ovf rises and is held high 10 cycles -> TF0=1 once, int_req=1 with int_vec=16'h000B two cycles later. On int_ack: TF0=0, in_service=2'b01, no second request while t0_ovf stays high.
- Priority: IE=8'h8F, IP=8'h08, IE0 and TF1 set in the same cycle -> int_vec=16'h001B (TF1 high level). After ack, IE0 is held off until reti, then int_vec=16'h0003 is requested.
- Nesting: serving low-level TF0 (in_service=01), high-level IE1 edge arrives -> int_req with int_vec=16'h0013, in_service=11 after ack. First reti -> 01, second reti -> 00.
- Level vs edge INT0: it0=0, pin held low -> IE0 survives ack and re-requests after reti. With it0=1, a single pin pulse gives one request and IE0 clears on ack.
- Withdrawal: in REQ for TF1, software tcon_we with wdata=4'h0 -> int_req=0 next cycle. A simultaneous t1_ovf rising edge instead keeps TF1=1.
- Reset mid-REQ: rst_n=0 one cycle while int_req=1 -> all outputs 0 next cycle. A held-high t0_ovf after reset sets TF0 once, because the previous-value flop resets to 0.
